// File: rtl/seven_seg_capture_pkg.sv
// Shared constants for the seven-segment capture block: glyph table, FSM states, timing.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sevseg_pkg;

  // Default settle window and the display driver's per-digit phase length
  localparam int STABLE_CYCLES_DEF = 4;
  localparam int PHASE_CYCLES      = 16;

  // Active-high segments, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // A byte always starts on the high digit, so WAIT_HI is the idle state
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } cap_state_t;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Multiplexed two-digit seven-segment display bus: shared anode select plus 7 segments.
// Latency: none (wires only).
// Backpressure: none; the display free-runs and the receiver just observes.
interface seven_seg_capture_if;
  logic       anode;
  logic [6:0] led;

  modport master (output anode, output led);
  modport slave  (input anode, input led);
endinterface

// File: rtl/seven_seg_capture_decoder.sv
// Inverse glyph table: segment pattern -> hex nibble, with legal and blank flags.
// Latency: combinational.
// Backpressure: not applicable.
module seg_pattern_decoder
  import sevseg_pkg::*;
(
  input  logic [6:0] led,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  // Blank is reported separately so callers can ignore it without flagging an error
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (led)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the byte shown on a multiplexed two-digit seven-segment bus (optional SEVSEG_CHANGE_ONLY_EN).
// Latency: STABLE_CYCLES+2 edges from the first edge seeing the final low digit to char_valid.
// Backpressure: none; pulses are single-cycle and the byte is held in char_out until replaced.
module seven_seg_capture
  import sevseg_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_capture_if.slave  disp,
  output logic [7:0]          char_out,
  output logic                char_valid,
  output logic                seg_err
);

  // The settle window must close inside one display phase or digits are never accepted
  if (STABLE_CYCLES < 1 || STABLE_CYCLES >= PHASE_CYCLES) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1..%0d", PHASE_CYCLES - 1);
  end

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  logic       anode_q;
  logic [6:0] led_q;
  logic [7:0] prev_q;
  logic [3:0] stab_cnt;
  logic [3:0] stab_nxt;
  logic       changed;
  logic       evt_nxt;
  logic       sample_evt;
  logic       smp_anode;
  logic [6:0] smp_led;

  logic [3:0] nib;
  logic       legal;
  logic       blank;

  cap_state_t state_q, state_d;
  logic [3:0] hi_nib, hi_nib_d;
  logic [7:0] char_d;
  logic       valid_d;
  logic       err_d;

  // Register the raw pins once before any comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q <= 1'b0;
      led_q   <= '0;
    end else begin
      anode_q <= disp.anode;
      led_q   <= disp.led;
    end
  end

  // Counter restarts on any change and saturates; the strobe fires only on the step into saturation
  always_comb begin
    changed  = ({anode_q, led_q} != prev_q);
    stab_nxt = changed ? 4'd1 : ((stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 4'd1);
    evt_nxt  = (stab_nxt == STAB_MAX) && (changed || (stab_cnt != STAB_MAX));
  end

  // Snapshot the settled pattern with the strobe so the FSM sees it even if the pins move on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      stab_cnt   <= '0;
      sample_evt <= 1'b0;
      smp_anode  <= 1'b0;
      smp_led    <= '0;
    end else begin
      prev_q     <= {anode_q, led_q};
      stab_cnt   <= stab_nxt;
      sample_evt <= evt_nxt;
      if (evt_nxt) begin
        smp_anode <= anode_q;
        smp_led   <= led_q;
      end
    end
  end

  seg_pattern_decoder u_dec (
    .led    (smp_led),
    .nibble (nib),
    .legal  (legal),
    .blank  (blank)
  );

`ifdef SEVSEG_CHANGE_ONLY_EN
  logic have_prev, have_prev_d;

  // Remembers that a byte has been reported since reset; char_out then equals the last reported byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) have_prev <= 1'b0;
    else     have_prev <= have_prev_d;
  end
`endif

  // Next-state and output decode, acting only on a settled non-blank digit
  always_comb begin
    state_d  = state_q;
    hi_nib_d = hi_nib;
    char_d   = char_out;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef SEVSEG_CHANGE_ONLY_EN
    have_prev_d = have_prev;
`endif
    if (sample_evt && !blank) begin
      case (state_q)
        WAIT_HI: begin
          if (smp_anode) begin
            if (legal) begin
              hi_nib_d = nib;
              state_d  = WAIT_LO;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WAIT_LO: begin
          if (legal) begin
            if (smp_anode) begin
              // Back-to-back high phases: the newer high digit wins
              hi_nib_d = nib;
            end else begin
              char_d  = {hi_nib, nib};
              state_d = WAIT_HI;
`ifdef SEVSEG_CHANGE_ONLY_EN
              valid_d     = !have_prev || (char_d != char_out);
              have_prev_d = 1'b1;
`else
              valid_d = 1'b1;
`endif
            end
          end else begin
            err_d    = 1'b1;
            hi_nib_d = 4'h0;
            state_d  = WAIT_HI;
          end
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_HI;
      hi_nib     <= 4'h0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      seg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_nib     <= hi_nib_d;
      char_out   <= char_d;
      char_valid <= valid_d;
      seg_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus random phases against a rule-level model.
// The model tracks run lengths of sampled pin values and applies the digit rules directly.
// Results appear two edges after the edge that completes a stable run.
`timescale 1ns/1ps
module tb_seven_seg_capture;

  localparam int S = 4;
`ifdef SEVSEG_CHANGE_ONLY_EN
  localparam bit CHG_ONLY = 1'b1;
`else
  localparam bit CHG_ONLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_out;
  logic       char_valid;
  logic       seg_err;

  always #5 clk = ~clk;

  seven_seg_capture_if bus ();

  seven_seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp       (bus),
    .char_out   (char_out),
    .char_valid (char_valid),
    .seg_err    (seg_err)
  );

  logic [6:0] glyph [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == p) r = i;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] last_pin;
  int         run;
  int         hi;
  logic       have_prev;
  logic [7:0] last_byte;
  logic       d1_u, d1_v, d1_e, d2_u, d2_v, d2_e;
  logic [7:0] d1_b, d2_b;
  logic       exp_v, exp_e;
  logic [7:0] exp_char;

  always @(posedge clk) begin
    logic [7:0] pin;
    int         n;
    logic       r_u, r_v, r_e;
    logic [7:0] r_b;
    if (rst) begin
      last_pin = 8'h00; run = 0; hi = -1; have_prev = 1'b0; last_byte = 8'h00;
      d1_u = 0; d1_v = 0; d1_e = 0; d1_b = 0;
      d2_u = 0; d2_v = 0; d2_e = 0; d2_b = 0;
      exp_v = 0; exp_e = 0; exp_char = 8'h00;
    end else begin
      exp_v = d2_v;
      exp_e = d2_e;
      if (d2_u) exp_char = d2_b;
      d2_u = d1_u; d2_v = d1_v; d2_e = d1_e; d2_b = d1_b;
      pin = {bus.anode, bus.led};
      if (pin == last_pin) begin
        if (run < 1000) run++;
      end else begin
        run = 1;
        last_pin = pin;
      end
      r_u = 0; r_v = 0; r_e = 0; r_b = 8'h00;
      if (run == S && pin[6:0] != 7'd0) begin
        n = lookup(pin[6:0]);
        if (pin[7]) begin
          if (n >= 0) hi = n;
          else begin r_e = 1; hi = -1; end
        end else if (hi >= 0) begin
          if (n >= 0) begin
            r_b = {4'(hi), 4'(n)};
            r_u = 1;
            r_v = CHG_ONLY ? (!have_prev || r_b != last_byte) : 1'b1;
            last_byte = r_b;
            have_prev = 1'b1;
          end else begin
            r_e = 1;
          end
          hi = -1;
        end
      end
      d1_u = r_u; d1_v = r_v; d1_e = r_e; d1_b = r_b;
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = -1;
  bit saw_38 = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    check("char_valid", char_valid, exp_v);
    check("seg_err", seg_err, exp_e);
    check("char_out", char_out, exp_char);
    check("exclusive", char_valid & seg_err, 0);
    if (char_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (char_out == 8'h38) saw_38 = 1'b1;
    end
    if (seg_err) err_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic a, input logic [6:0] l, input int n);
    bus.anode = a;
    bus.led   = l;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_byte(input logic [7:0] b);
    hold(1'b1, glyph[b[7:4]], 16);
    hold(1'b0, glyph[b[3:0]], 16);
  endtask

  initial begin
    int v0, e0, lo_start, r, len;
    logic [6:0] pat;
    rst = 1'b1;
    bus.anode = 1'b0;
    bus.led   = 7'd0;
    repeat (3) @(negedge clk);
    check("rst_char_out", char_out, 8'h00);
    check("rst_char_valid", char_valid, 0);
    check("rst_seg_err", seg_err, 0);
    rst = 1'b0;
    hold(1'b0, 7'd0, 4);

    // Static A5, twice; first pulse lands on the (S+2)th edge counting the first lo edge as 1
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, 7'b1110111, 16);
    lo_start = cyc;
    hold(1'b0, 7'b1011011, 16);
    check("a5_latency", last_valid_cyc, lo_start + S + 2);
    show_byte(8'hA5);
    check("a5_char", char_out, 8'hA5);
    check("a5_pulses", valid_cnt - v0, CHG_ONLY ? 1 : 2);
    check("a5_errs", err_cnt - e0, 0);

    // Glitch to the 8 glyph inside the lo phase of 3C
    v0 = valid_cnt;
    hold(1'b1, glyph[3], 16);
    hold(1'b0, glyph[12], 2);
    hold(1'b0, 7'b1111111, 2);
    hold(1'b0, glyph[12], 12);
    check("glitch_char", char_out, 8'h3C);
    check("glitch_pulses", valid_cnt - v0, 1);
    check("glitch_no38", saw_38, 0);

    // Illegal high glyph, then a clean 07
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, 7'b1010101, 16);
    hold(1'b0, glyph[0], 16);
    check("illegal_err", err_cnt - e0, 1);
    check("illegal_nopair", valid_cnt - v0, 0);
    show_byte(8'h07);
    check("illegal_next", char_out, 8'h07);
    check("illegal_pulses", valid_cnt - v0, 1);

    // Orphan lo, blank, hi F, hi E, lo 1 straight after a reset
    rst = 1'b1;
    hold(1'b0, 7'd0, 2);
    rst = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b0, glyph[1], 16);
    hold(1'b1, 7'd0, 16);
    hold(1'b1, glyph[15], 16);
    hold(1'b1, glyph[14], 16);
    hold(1'b0, glyph[1], 16);
    check("orphan_char", char_out, 8'hE1);
    check("orphan_pulses", valid_cnt - v0, 1);
    check("orphan_errs", err_cnt - e0, 0);

    // Async reset while holding hi 9; the lone lo phase afterwards yields nothing
    hold(1'b1, glyph[9], 16);
    bus.anode = 1'b0;
    bus.led   = glyph[4];
    rst = 1'b1;
    #1;
    check("async_char_out", char_out, 8'h00);
    check("async_valid", char_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    hold(1'b0, glyph[4], 15);
    check("async_lone_lo", valid_cnt - v0, 0);
    show_byte(8'h26);
    check("async_next", char_out, 8'h26);
    check("async_pulses", valid_cnt - v0, 1);

    // Four refreshes of 42 then one of 43
    v0 = valid_cnt;
    repeat (4) show_byte(8'h42);
    show_byte(8'h43);
    check("chg_char", char_out, 8'h43);
    check("chg_pulses", valid_cnt - v0, CHG_ONLY ? 2 : 5);

    // Random phases, including short glitches, junk patterns and blanks
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       pat = glyph[$urandom_range(0, 15)];
      else if (r == 7) pat = 7'd0;
      else             pat = 7'($urandom);
      len = (r == 9) ? $urandom_range(1, S) : $urandom_range(1, 20);
      hold(1'($urandom_range(0, 1)), pat, len);
    end
    hold(1'b0, 7'd0, S + 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the multiplexed two-digit seven-segment display bus.
- Monitors the shared anode-select line and 7 segment lines.
- Waits for each digit phase to settle, then decodes the segment pattern back to a hex nibble and reassembles the displayed byte.
- Used for display loopback checking, and for capturing the byte shown by another board over a header.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical registered samples of {anode, led} needed before a digit is accepted. Legal range 1..15, which must be shorter than the display phase of 16 cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- anode  input  1  digit select: 1 = high digit (byte[7:4]) shown, 0 = low digit (byte[3:0]) shown
- led  input  7  segments active-high, led[6]=a ... led[0]=g
- char_out  output  8  last assembled byte {hi, lo}
- char_valid  output  1  one-cycle pulse when char_out is updated
- seg_err  output  1  one-cycle pulse when an accepted pattern is not a legal hex glyph

Behaviour:
- Reset (async, rst=1):
  - anode_q, led_q, stab_cnt, hi_nib, char_out all set to 0.
  - char_valid=0, seg_err=0, FSM in WAIT_HI.
  - Reset mid-capture discards any held hi nibble.
- Input stage: anode and led are registered each cycle into anode_q/led_q.
- Stability counter (stab_cnt, 4 bits):
  - Set to 1 when {anode_q, led_q} differs from its previous-cycle value; otherwise increments, saturating at STABLE_CYCLES.
  - Internal strobe sample_evt fires exactly once per stable window, in the cycle stab_cnt becomes STABLE_CYCLES.
- Glyph decode:
  - Patterns 0..F use the team glyph set: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - 7'b0000000 is blank. A blank sample_evt is ignored: no error, no state change.
  - Any other pattern is illegal.
- FSM, which acts only on sample_evt:
  - WAIT_HI, anode_q=1, legal: hi_nib <= nibble, go to WAIT_LO.
  - WAIT_HI, anode_q=1, illegal: seg_err pulse, stay in WAIT_HI.
  - WAIT_HI, anode_q=0: ignored. The byte always starts on a high digit.
  - WAIT_LO, anode_q=0, legal: char_out <= {hi_nib, nibble}, char_valid pulse, go to WAIT_HI.
  - WAIT_LO, anode_q=0, illegal: seg_err pulse, drop hi_nib, go to WAIT_HI.
  - WAIT_LO, anode_q=1, legal: a new high phase arrived without a low one, so hi_nib is reloaded and the FSM stays in WAIT_LO.
  - WAIT_LO, anode_q=1, illegal: seg_err pulse, go to WAIT_HI.
- Latency:
  - char_valid and seg_err are registered one cycle after sample_evt.
  - Total is STABLE_CYCLES+2 cycles from the first clock edge at which the final low-digit value is present on the pins.
- Exclusivity and hold:
  - char_valid and seg_err are never asserted in the same cycle.
  - char_out holds its value between pulses.
- Segment glitches: a glitch shorter than STABLE_CYCLES restarts the counter and produces no event. A digit phase that never stabilises is silently skipped.

Optional Feature:
- Macro SEVSEG_CHANGE_ONLY_EN.
- Defined:
  - char_valid pulses only if the assembled byte differs from the last byte that produced a pulse, or on the first byte after reset (tracked by a have_prev flag).
  - char_out still updates on every completed byte.
- Undefined: char_valid pulses on every completed hi/lo pair, so a static display yields one pulse per 32-cycle refresh.

Decomposition:
- Package sevseg_pkg holds:
  - glyph constants SEG_0..SEG_F and SEG_BLANK;
  - FSM state encoding (WAIT_HI, WAIT_LO);
  - default STABLE_CYCLES;
  - display phase length 16.
- Sub-module seg_pattern_decoder: combinational, led[6:0] in; nibble[3:0], legal and blank out. It is the exact inverse of the display glyph table and is reusable by test benches.

Test Plan:
- Static byte: drive the display driver pattern for 8'hA5 (hi phase led=1110111, lo phase led=1011011, 16 cycles each) -> char_out=8'hA5 with a char_valid pulse STABLE_CYCLES+2 cycles into each lo phase, and seg_err never set.
- Glitch: during the lo phase of 8'h3C, force led to 1111111 for 2 cycles with STABLE_CYCLES=4 -> no 8'h38 is emitted, and char_out=8'h3C.
- Illegal glyph: hi phase led=1010101 -> seg_err pulses once, no char_valid for that pair, and the next clean pair 8'h07 is captured.
- Blank and orphan: lo phase first after reset, then blank, then hi=F, hi=E, lo=1 -> only 8'hE1 is emitted, with no errors.
- Async reset: assert rst for 1 cycle while in WAIT_LO after hi=9 -> outputs read 0, the following lo phase alone produces nothing, and the next full pair is captured.
- Change-only (with SEVSEG_CHANGE_ONLY_EN): hold 8'h42 for 4 refresh periods, then change to 8'h43 -> exactly 2 char_valid pulses (one for 8'h42, one for 8'h43). Without the macro the same stimulus gives 5 pulses.
